// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: segment bit order,
// hex glyphs and the nibble decoder.
package seg7_scan_ctrl_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Glyphs in {g,f,e,d,c,b,a} order, active-high
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg7_decode = GLYPH_0;
      4'h1:    seg7_decode = GLYPH_1;
      4'h2:    seg7_decode = GLYPH_2;
      4'h3:    seg7_decode = GLYPH_3;
      4'h4:    seg7_decode = GLYPH_4;
      4'h5:    seg7_decode = GLYPH_5;
      4'h6:    seg7_decode = GLYPH_6;
      4'h7:    seg7_decode = GLYPH_7;
      4'h8:    seg7_decode = GLYPH_8;
      4'h9:    seg7_decode = GLYPH_9;
      4'hA:    seg7_decode = GLYPH_A;
      4'hB:    seg7_decode = GLYPH_B;
      4'hC:    seg7_decode = GLYPH_C;
      4'hD:    seg7_decode = GLYPH_D;
      4'hE:    seg7_decode = GLYPH_E;
      4'hF:    seg7_decode = GLYPH_F;
      default: seg7_decode = 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a stable-sample
// counter; emits the debounced level and a one-cycle pulse on its falling edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic fall
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          fall_reg;
  logic [CW-1:0] cnt_reg;

  // cnt_reg counts consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts the count, so short glitches are absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      fall_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      fall_reg  <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
        level_reg <= sync2_reg;
        fall_reg  <= level_reg & ~sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with prescaler, dead-time blanking,
// frame-synchronous data update, leading-zero blanking and a page selector.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 16,
  parameter int DEB_CYCLES  = 200000,
  parameter int NUM_PAGES   = 32,
  localparam int DSW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int PW  = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  input  logic                    next_btn,
  output logic [DSW-1:0]          dig_sel,
  output logic [7:0]              seg,
  output logic [PW-1:0]           page
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [DSW-1:0]        dig_sel_reg, dig_sel_next;
  logic [DW-1:0]         shadow_reg, shadow_next;
  logic [DW-1:0]         pending_reg, pending_next;
  logic                  pending_valid_reg, pending_valid_next;
  logic [7:0]            seg_reg, seg_next;
  logic [PW-1:0]         page_reg, page_next;
  logic                  tick;
  logic                  frame_end;
  logic                  last_digit;
  logic                  lz_run;
  logic [NUM_DIGITS-1:0] lz;
  logic [3:0]            nib [NUM_DIGITS];
  logic                  btn_fall;
  logic                  btn_level_unused;

  // Digit 0 is the most significant nibble of the shadowed word.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib[gi] = shadow_reg[DW-1-4*gi -: 4];
  end

  // lz[i]: every digit from 0 up to and including i is zero
  always_comb begin
    lz_run = 1'b1;
    lz     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lz_run = lz_run & (nib[i] == 4'h0);
      lz[i]  = lz_run;
    end
  end

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(next_btn),
    .level  (btn_level_unused),
    .fall   (btn_fall)
  );

  always_comb begin
    tick       = (cnt_reg == CW'(SCAN_DIV - 1));
    last_digit = (dig_sel_reg == DSW'(NUM_DIGITS - 1));
    frame_end  = tick & last_digit;

    cnt_next     = tick ? '0 : cnt_reg + 1'b1;
    dig_sel_next = dig_sel_reg;
    if (tick) begin
      dig_sel_next = last_digit ? '0 : dig_sel_reg + 1'b1;
    end

    // A load coinciding with the frame boundary goes straight to the shadow.
    pending_next       = pending_reg;
    pending_valid_next = pending_valid_reg;
    shadow_next        = shadow_reg;
    if (load) begin
      pending_next       = data;
      pending_valid_next = 1'b1;
    end
    if (frame_end) begin
      if (load) begin
        shadow_next = data;
      end else if (pending_valid_reg) begin
        shadow_next = pending_reg;
      end
      pending_valid_next = 1'b0;
    end

    // Computed from the current slot, so seg trails dig_sel by one cycle.
    seg_next = SEG_OFF;
    if (cnt_reg >= CW'(DEAD_CYCLES)) begin
      seg_next[SEG_DP] = dp_mask[dig_sel_reg];
      if (!(blank_lz && lz[dig_sel_reg] && !last_digit)) begin
        seg_next[SEG_G:SEG_A] = seg7_decode(nib[dig_sel_reg]);
      end
    end

    page_next = page_reg;
    if (btn_fall) begin
      page_next = (page_reg == PW'(NUM_PAGES - 1)) ? '0 : page_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg           <= '0;
      dig_sel_reg       <= '0;
      shadow_reg        <= '0;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
      seg_reg           <= SEG_OFF;
      page_reg          <= '0;
    end else begin
      cnt_reg           <= cnt_next;
      dig_sel_reg       <= dig_sel_next;
      shadow_reg        <= shadow_next;
      pending_reg       <= pending_next;
      pending_valid_reg <= pending_valid_next;
      seg_reg           <= seg_next;
      page_reg          <= page_next;
    end
  end

  assign dig_sel = dig_sel_reg;
  assign seg     = seg_reg;
  assign page    = page_reg;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment display controller for the board debug path; shows a CPU register value (`RegBus`-style hex word) on NUM_DIGITS time-multiplexed digits.
- Additions over a plain scanner:
  - programmable scan prescaler;
  - inter-digit blanking (anti-ghosting);
  - tear-free frame-synchronous data update;
  - leading-zero blanking and per-digit decimal points;
  - debounced page-select button that steps a register/page index with wrap.

Parameters:
- NUM_DIGITS, 8, digits on the display; data width = 4*NUM_DIGITS
- SCAN_DIV, 50000, clk cycles per digit slot (>=2)
- DEAD_CYCLES, 16, cycles at the start of each slot with segments forced off (< SCAN_DIV)
- DEB_CYCLES, 200000, cycles the synchronised button must be stable before it is accepted
- NUM_PAGES, 32, page index range 0..NUM_PAGES-1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- data  in  4*NUM_DIGITS  value to display, nibble [4*NUM_DIGITS-1 -: 4] on digit 0
- load  in  1  capture strobe for data, one cycle
- dp_mask  in  NUM_DIGITS  bit i lights the decimal point of digit i
- blank_lz  in  1  1 = suppress leading-zero digits
- next_btn  in  1  raw asynchronous push button, active-low press
- dig_sel  out  clog2(NUM_DIGITS)  index of the digit currently driven
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-high; 0 -> 0x3F, 1 -> 0x06, ... F -> 0x71
- page  out  clog2(NUM_PAGES)  selected page/register index

Behaviour:
- Reset (async assert, sync release): seg=0, dig_sel=0, page=0; prescaler, dead counter, shadow, pending, pending_valid and debouncer state all 0.
- Prescaler:
  - counts 0..SCAN_DIV-1;
  - tick is a one-cycle pulse when count==SCAN_DIV-1, and count returns to 0 on that cycle.
- Digit scan:
  - on tick, dig_sel advances by 1, wrapping NUM_DIGITS-1 -> 0;
  - the frame boundary is a tick with dig_sel==NUM_DIGITS-1.
- Data path:
  - load captures data into pending and sets pending_valid;
  - on a frame boundary, shadow takes the new value and pending_valid clears; the new value is data if load is high in that same cycle, otherwise pending if pending_valid, otherwise shadow is unchanged;
  - a second load before the boundary overwrites pending (last wins).
  - Display content therefore never changes mid-frame. Update latency is up to NUM_DIGITS*SCAN_DIV cycles.
- Output stage (registered, one cycle after the dig_sel update):
  - seg=0 for the first DEAD_CYCLES cycles of each slot;
  - otherwise seg = {dp_mask[dig_sel], decode(nibble)};
  - dp_mask and blank_lz are sampled live, not shadowed.
- Leading-zero blanking:
  - with blank_lz=1, digit i shows segments off (dp still honoured) if all nibbles of digits 0..i are zero and i != NUM_DIGITS-1;
  - the last digit always displays, so value 0 shows a single "0".
- Page select:
  - next_btn passes a 2-FF synchroniser, then the debouncer sub-module;
  - the debounced level changes only after DEB_CYCLES consecutive equal samples;
  - on a debounced 1->0 transition, page increments, wrapping NUM_PAGES-1 -> 0;
  - release produces no increment; glitches shorter than DEB_CYCLES produce none.
- Reset mid-operation: all state returns to reset values immediately; a pending load is discarded.
- Undefined nibbles cannot occur; the decoder has a default of 0x00.

Decomposition:
- Shared package/defines:
  - seven-segment glyph constants 0-F;
  - segment bit-order constants;
  - a SEG_OFF constant.
- Sub-module btn_debounce (param DEB_CYCLES): sync + stable counter, outputs level and a fall pulse.
- Prescaler, scan, shadow and decode stay in seg7_scan_ctrl.

Test Plan:
All scenarios use NUM_DIGITS=8, SCAN_DIV=4, DEAD_CYCLES=1, DEB_CYCLES=3, NUM_PAGES=4.
1. Reset then load data=0x1234ABCD -> after the next frame boundary, one frame shows seg sequence 0x06,0x5B,0x4F,0x66,0x77,0x7C,0x39,0x5E on dig_sel 0..7. Each digit is driven for 3 cycles after 1 dead cycle of 0x00.
2. Load 0x11111111 mid-frame at dig_sel=3 -> digits 4..7 of the current frame still show the old value; the change appears exactly at dig_sel=0 of the next frame. A load in the boundary cycle is taken directly.
3. blank_lz=1, data=0x00000A05 -> digits 0..4 are 0x00, digit 5=0x77, digit 6=0x3F, digit 7=0x6D. With data=0 only digit 7 shows 0x3F. With dp_mask=0x01 and data=0, digit 0 shows 0x80.
4. next_btn pressed 0 for 10 cycles, four times with release gaps -> page 1,2,3,0. A 2-cycle low glitch -> page unchanged.
5. rst_n asserted asynchronously mid-slot with a pending load -> seg=0, dig_sel=0, page=0 immediately. After release, the old pending data never appears.
